bullet_ctrl: RTL and testbench
==============================

# bullet_ctrl

Projectile scheduler for the shooter playfield. Shares a fixed pool of bullet slots between successive fire requests from the player ship: launches, advances and retires bullets once per video frame, and enforces a refire cooldown. Produces the per-pixel `bull_on` term consumed by the playfield RGB priority mux, in place of the single static bullet drawn above the ship.

## Interface
Parameters:
- `NUM_BULLETS`, 4: number of bullet slots (1..8).
- `BULL_V`, 4: upward pixels per frame.
- `COOLDOWN`, 8: frames between launches (0..15).
- `BULL_W`, 4: bullet width in pixels.
- `BULL_H`, 5: bullet height in pixels.
- `LAUNCH_Y`, 460: top row of a freshly launched bullet.
- `TOP_Y`, 3: first row below the top wall.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pix_x`, `pix_y`  in  11 each  current scan position.
- `ship_x`  in  11  ship left edge, registered in the player logic.
- `fire`  in  1  fire button, active-low, asynchronous to `clk`.
- `hit_clr`  in  `NUM_BULLETS`  per-slot retire request from collision logic, one-cycle pulse.
- `bull_on`  out  1  current pixel lies inside any active bullet.
- `slot_active`  out  `NUM_BULLETS`  slot occupancy.
- `active_cnt`  out  4  population count of `slot_active`.
- `shot`  out  1  one-cycle pulse on each launch (sound/score hook).

## Operation
- `fire` passes through a 2-flop synchronizer (reset value 1). A falling edge of the synchronized signal sets `pend`. `pend` clears on every frame tick, whether or not the request is served.
- Internal `frame_tick` = (`pix_y`==481) && (`pix_x`==0). All slot and cooldown updates happen only on `frame_tick`, except `hit_clr`.
- Per slot: `act`, `x[10:0]`, `y[10:0]`.
- Controller FSM:
  - READY: cooldown is 0.
  - COOL: cooldown counter `cd` > 0. On each tick `cd` decrements; when it reaches 0 the FSM returns to READY.
- Order of updates on a tick:
  1. Advance and retire. For each active slot: if `y` < `TOP_Y`+`BULL_V`, clear `act`; otherwise `y` ← `y`−`BULL_V`.
  2. Launch. Launch when FSM is READY, `pend`=1, and at least one slot was inactive before this tick. The lowest-index free slot gets `act`=1, `x`=`ship_x`+3, `y`=`LAUNCH_Y`. Then `cd` ← `COOLDOWN`, FSM → COOL (stays READY if `COOLDOWN`=0), and `shot`=1 for that cycle.
  3. Drop. A press while in COOL, or with all slots busy, is dropped and is not queued.
- `hit_clr[i]` clears `act[i]` in any cycle. If it coincides with a tick, the clear wins over advance and launch for that slot. A slot freed by step 1 or by `hit_clr` in the same tick is not eligible for launch until the next tick.
- `bull_on` = OR over active slots of (`x`≤`pix_x`≤`x`+`BULL_W`−1) && (`y`≤`pix_y`≤`y`+`BULL_H`−1). All arithmetic is 11-bit unsigned. Inactive slots never contribute.

## Timing
- Reset (async assert, sync release): all `act`=0, `x`=`y`=0, `cd`=0, FSM READY, `pend`=0, sync flops=1. Outputs: `bull_on`=0, `slot_active`=0, `active_cnt`=0, `shot`=0.
- `fire` falling edge → `pend` set 3 cycles later (2 sync + edge detect).
- Launch is visible at the next frame tick after `pend` is set. `slot_active`/`active_cnt` update the cycle after the tick. `shot` is high in that same cycle for exactly 1 cycle.
- `bull_on` is combinational from the registers and the current `pix_x`/`pix_y`, with zero cycles latency, matching the rest of the RGB mux.
- `hit_clr` takes effect on `slot_active` the next cycle.
- If `reset` asserts mid-frame, all bullets vanish immediately and no launch occurs until a new press after reset release.

## Configuration
- `BULLET_AUTOFIRE_EN` defined: `pend` is the level of the synchronized `fire` (low = pressed). Holding fire launches on every tick where the FSM is READY and a slot is free, i.e. one shot per `COOLDOWN`+1 frames.
- Undefined: edge-triggered only. One launch per press; holding fire produces a single shot.

## Test plan
- Reset, `ship_x`=315, one press → next tick: slot0 active, x=318, y=460, `shot` pulse; one tick later y=456; `bull_on`=1 at (318,456), 0 at (322,456).
- Press again during cooldown (`COOLDOWN`=8, press 3 frames after the launch) → no launch; press 9 frames after the launch → slot1 launches.
- Fill all 4 slots using `COOLDOWN`=0 and 4 presses; 5th press → dropped, `active_cnt`=4, no `shot`.
- Single bullet from y=460, no hits → advances to y=4; at y=4 (< 3+4) the next tick retires it; `active_cnt` returns to 0 after 115 ticks.
- Assert `hit_clr`=4'b0001 on the same cycle as a tick with slot0 active and a press pending → slot0 cleared, launch goes to slot1.
- With `BULLET_AUTOFIRE_EN`, `COOLDOWN`=2, hold fire 12 frames → launches at frames 1, 4, 7, 10; without the macro → a single launch.

Source files
------------

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: bullet slot pool with per-frame launch/advance/retire, refire cooldown and pixel hit term.
// Define BULLET_AUTOFIRE_EN to launch on every ready frame while fire is held instead of once per press.
module bullet_ctrl #(
    parameter int NUM_BULLETS = 4,
    parameter int BULL_V      = 4,
    parameter int COOLDOWN    = 8,
    parameter int BULL_W      = 4,
    parameter int BULL_H      = 5,
    parameter int LAUNCH_Y    = 460,
    parameter int TOP_Y       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            pix_x,
    input  logic [10:0]            pix_y,
    input  logic [10:0]            ship_x,
    input  logic                   fire,
    input  logic [NUM_BULLETS-1:0] hit_clr,
    output logic                   bull_on,
    output logic [NUM_BULLETS-1:0] slot_active,
    output logic [3:0]             active_cnt,
    output logic                   shot
);
    typedef enum logic {READY, COOL} state_t;
    state_t                 state_q;
    logic [3:0]             cd_q;
    logic                   s1_q, s2_q, pend, tick, launch, shot_q;
    logic [NUM_BULLETS-1:0] act_q, act_d, free;
    logic [10:0]            x_q [NUM_BULLETS];
    logic [10:0]            x_d [NUM_BULLETS];
    logic [10:0]            y_q [NUM_BULLETS];
    logic [10:0]            y_d [NUM_BULLETS];
    logic [2:0]             sel;
    logic [3:0]             cnt_q, cnt_d;

    assign tick = pix_y == 11'd481 && pix_x == 11'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= fire;
            s2_q <= s1_q;
        end
    end

`ifdef BULLET_AUTOFIRE_EN
    assign pend = ~s2_q;
`else
    logic s3_q, pend_q;
    // a request lives only until the next frame tick, served or not
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_q   <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            s3_q   <= s2_q;
            pend_q <= tick ? 1'b0 : pend_q | (s3_q & ~s2_q);
        end
    end
    assign pend = pend_q;
`endif

    // slots cleared by hit_clr this cycle are not launch candidates
    always_comb begin
        free   = ~act_q & ~hit_clr;
        launch = tick && state_q == READY && pend && |free;
        sel    = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--)
            if (free[i]) sel = 3'(i);
        act_d = act_q;
        x_d   = x_q;
        y_d   = y_q;
        cnt_d = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (tick && act_q[i]) begin
                if (y_q[i] < 11'(TOP_Y + BULL_V)) act_d[i] = 1'b0;
                else y_d[i] = y_q[i] - 11'(BULL_V);
            end
            if (launch && sel == 3'(i)) begin
                act_d[i] = 1'b1;
                x_d[i]   = ship_x + 11'd3;
                y_d[i]   = 11'(LAUNCH_Y);
            end
            if (hit_clr[i]) act_d[i] = 1'b0;
            cnt_d = cnt_d + 4'(act_d[i]);
        end
    end

    always_comb begin
        bull_on = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++)
            if (act_q[i] && pix_x >= x_q[i] && pix_x <= x_q[i] + 11'(BULL_W - 1) &&
                pix_y >= y_q[i] && pix_y <= y_q[i] + 11'(BULL_H - 1))
                bull_on = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= READY;
            cd_q    <= '0;
            act_q   <= '0;
            cnt_q   <= '0;
            shot_q  <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            act_q  <= act_d;
            x_q    <= x_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            shot_q <= launch;
            if (launch) begin
                cd_q    <= 4'(COOLDOWN);
                state_q <= COOLDOWN == 0 ? READY : COOL;
            end else if (tick && state_q == COOL) begin
                cd_q    <= cd_q - 4'd1;
                state_q <= cd_q == 4'd1 ? READY : COOL;
            end
        end
    end

    assign slot_active = act_q;
    assign active_cnt  = cnt_q;
    assign shot        = shot_q;
endmodule

// File: tb/tb_bullet_ctrl.sv
// tb_bullet_ctrl: directed bench for bullet_ctrl with a frame-level model checked every cycle.
module tb_bullet_ctrl;
    localparam int NB = 4, BV = 4, CD = 8, BW = 4, BH = 5, LY = 460, TY = 3;

    logic          clk = 1'b0, reset = 1'b0, fire = 1'b1;
    logic [10:0]   pix_x = 11'd310, pix_y = 11'd100, ship_x = 11'd315;
    logic [NB-1:0] hit_clr = '0;
    logic          bull_on, shot;
    logic [NB-1:0] slot_active;
    logic [3:0]    active_cnt;
    int            n_tests = 0, n_fail = 0;

    bullet_ctrl #(
        .NUM_BULLETS(NB), .BULL_V(BV), .COOLDOWN(CD), .BULL_W(BW),
        .BULL_H(BH), .LAUNCH_Y(LY), .TOP_Y(TY)
    ) dut (
        .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .ship_x(ship_x),
        .fire(fire), .hit_clr(hit_clr), .bull_on(bull_on), .slot_active(slot_active),
        .active_cnt(active_cnt), .shot(shot)
    );

    always #5 clk = ~clk;

    // frame-level model: slots as plain ints, cooldown as a frame count, fire as a sample history
    bit m_act [NB];
    int m_x [NB];
    int m_y [NB];
    int m_cd;
    bit m_pend, m_shot;
    bit fh [3];

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_act[i] = 1'b0;
            m_x[i] = 0;
            m_y[i] = 0;
        end
        m_cd = 0;
        m_pend = 1'b0;
        m_shot = 1'b0;
        for (int i = 0; i < 3; i++) fh[i] = 1'b1;
    endtask

    task automatic model_step();
        bit fall, req;
        int fs;
        fall = !fh[1] && fh[2];
`ifdef BULLET_AUTOFIRE_EN
        req = !fh[1];
`else
        req = m_pend;
`endif
        m_shot = 1'b0;
        if (pix_y == 11'd481 && pix_x == 11'd0) begin
            fs = -1;
            for (int i = NB - 1; i >= 0; i--)
                if (!m_act[i] && !hit_clr[i]) fs = i;
            for (int i = 0; i < NB; i++)
                if (m_act[i]) begin
                    if (m_y[i] < TY + BV) m_act[i] = 1'b0;
                    else m_y[i] = m_y[i] - BV;
                end
            if (m_cd == 0 && req && fs >= 0) begin
                m_act[fs] = 1'b1;
                m_x[fs] = (int'(ship_x) + 3) % 2048;
                m_y[fs] = LY;
                m_cd = CD;
                m_shot = 1'b1;
            end else if (m_cd > 0) m_cd--;
            m_pend = 1'b0;
        end else m_pend = m_pend | fall;
        for (int i = 0; i < NB; i++)
            if (hit_clr[i]) m_act[i] = 1'b0;
        fh[2] = fh[1];
        fh[1] = fh[0];
        fh[0] = fire;
    endtask

    function automatic bit exp_bull();
        int px = int'(pix_x), py = int'(pix_y);
        for (int i = 0; i < NB; i++)
            if (m_act[i] && px >= m_x[i] && px <= (m_x[i] + BW - 1) % 2048 &&
                py >= m_y[i] && py <= (m_y[i] + BH - 1) % 2048)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare();
        int cnt = 0;
        logic [NB-1:0] sa;
        for (int i = 0; i < NB; i++) begin
            sa[i] = m_act[i];
            cnt += int'(m_act[i]);
        end
        check("slot_active", 32'(slot_active), 32'(sa));
        check("active_cnt", 32'(active_cnt), cnt);
        check("shot", 32'(shot), 32'(m_shot));
        check("bull_on", 32'(bull_on), 32'(exp_bull()));
    endtask

    task automatic drive(input logic [10:0] x, input logic [10:0] y, input logic [NB-1:0] h);
        @(posedge clk);
        model_step();
        #1;
        pix_x = x;
        pix_y = y;
        hit_clr = h;
        @(negedge clk);
        compare();
    endtask

    task automatic cyc();
        logic [10:0] y;
        y = $urandom_range(0, 1) == 1 ? 11'(450 + $urandom_range(0, 20)) : 11'($urandom_range(0, 480));
        drive(11'(310 + $urandom_range(0, 20)), y, '0);
    endtask

    task automatic tick(input logic [NB-1:0] h);
        drive(11'd0, 11'd481, h);
    endtask

    task automatic press_tick(input logic [NB-1:0] h);
        fire = 1'b0;
        repeat (3) cyc();
        tick(h);
        fire = 1'b1;
    endtask

    task automatic probe(input int x, input int y, input bit exp, input string name);
        drive(11'(x), 11'(y), '0);
        check(name, 32'(bull_on), 32'(exp));
    endtask

    initial begin
        int n, shots;
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_slots", 32'(slot_active), 0);
        check("rst_cnt", 32'(active_cnt), 0);
        check("rst_shot", 32'(shot), 0);
        check("rst_bull", 32'(bull_on), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        compare();

        press_tick('0);
        cyc();
        check("launch_shot", 32'(shot), 1);
        check("launch_slots", 32'(slot_active), 32'b0001);
        check("launch_cnt", 32'(active_cnt), 1);
        probe(318, 460, 1, "b_tl");
        check("shot_one_cycle", 32'(shot), 0);
        probe(322, 460, 0, "b_right");
        probe(317, 460, 0, "b_left");
        probe(321, 464, 1, "b_br");
        probe(318, 465, 0, "b_below");
        probe(318, 459, 0, "b_above");
        tick('0);
        cyc();
        probe(318, 456, 1, "adv_tl");
        probe(322, 456, 0, "adv_right");
        probe(318, 460, 1, "adv_bot");
        probe(318, 461, 0, "adv_below");

        tick('0);
        press_tick('0);
        cyc();
        check("cool_drop_shot", 32'(shot), 0);
        check("cool_drop_slots", 32'(slot_active), 32'b0001);
        repeat (5) tick('0);
        press_tick('0);
        cyc();
        check("relaunch_shot", 32'(shot), 1);
        check("relaunch_slots", 32'(slot_active), 32'b0011);
        repeat (2) begin
            repeat (8) tick('0);
            press_tick('0);
            cyc();
        end
        check("full_slots", 32'(slot_active), 32'b1111);
        check("full_cnt", 32'(active_cnt), 4);
        repeat (8) tick('0);
        press_tick('0);
        cyc();
        check("busy_drop_shot", 32'(shot), 0);
        check("busy_drop_cnt", 32'(active_cnt), 4);

        drive(11'd318, 11'd100, 4'b0010);
        cyc();
        check("hit_slots", 32'(slot_active), 32'b1101);
        check("hit_cnt", 32'(active_cnt), 3);
        ship_x = 11'd100;
        press_tick(4'b0001);
        cyc();
        check("hit_tick_shot", 32'(shot), 1);
        check("hit_tick_slots", 32'(slot_active), 32'b1110);
        probe(103, 460, 1, "hs_tl");
        probe(106, 464, 1, "hs_br");
        probe(107, 460, 0, "hs_right");
        probe(102, 462, 0, "hs_left");

        n = 0;
        while (slot_active != '0 && n < 200) begin
            tick('0);
            cyc();
            n++;
        end
        check("drain_cnt", 32'(active_cnt), 0);

        ship_x = 11'd315;
        press_tick('0);
        cyc();
        check("life_shot", 32'(shot), 1);
        n = 0;
        while (slot_active != '0 && n < 200) begin
            tick('0);
            cyc();
            n++;
            if (n == 114) begin
                check("life_alive_y4", 32'(slot_active), 32'b0001);
                probe(318, 4, 1, "life_y4");
                probe(318, 8, 1, "life_y8");
                probe(318, 9, 0, "life_y9");
                probe(318, 3, 0, "life_y3");
            end
        end
        check("life_ticks", n, 115);

        fire = 1'b0;
        repeat (3) cyc();
        shots = 0;
        repeat (12) begin
            tick('0);
            cyc();
            if (shot) shots++;
            cyc();
        end
        fire = 1'b1;
        repeat (3) cyc();
`ifdef BULLET_AUTOFIRE_EN
        check("hold_shots", shots, 2);
`else
        check("hold_shots", shots, 1);
`endif

        check("pre_rst_busy", 32'(active_cnt != 4'd0), 1);
        fire = 1'b0;
        repeat (4) cyc();
        fire = 1'b1;
        repeat (3) cyc();
        @(posedge clk);
        model_step();
        #1 reset = 1'b1;
        model_reset();
        #1;
        check("mid_rst_slots", 32'(slot_active), 0);
        check("mid_rst_cnt", 32'(active_cnt), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        compare();
        cyc();
        tick('0);
        cyc();
        check("post_rst_no_shot", 32'(shot), 0);
        check("post_rst_slots", 32'(slot_active), 0);
        press_tick('0);
        cyc();
        check("post_rst_shot", 32'(shot), 1);
        check("post_rst_launch", 32'(slot_active), 32'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
